sw_operand_sequencer: RTL



---
 rtl/sw_operand_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sw_operand_sequencer.sv
// Switch-bank operand loader and LED result pager for a start/valid arithmetic unit.
// Optional build macro SEQ_ECHO_EN: live switch preview on the LEDs while loading.
module sw_operand_sequencer #(
  parameter int SW_W    = 16,
  parameter int WORD_W  = 32,
  parameter int NUM_OPS = 2,
  parameter int CTRL_W  = 5,
  parameter int FLAG_W  = 5,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SW_W-1:0]           sw,
  input  logic                      step,
  output logic [SW_W-1:0]           led,
  output logic [NUM_OPS*WORD_W-1:0] op_bus,
  output logic [CTRL_W-1:0]         ctrl,
  output logic                      start,
  input  logic                      valid_in,
  input  logic [WORD_W-1:0]         result_in,
  input  logic [FLAG_W-1:0]         flags_in,
  output logic                      busy,
  output logic                      timed_out
);

  localparam int PAGES = WORD_W / SW_W;
  localparam int NSLOT = NUM_OPS * PAGES;
  localparam int OP_W  = $clog2(NUM_OPS + 1);
  localparam int PG_W  = $clog2(PAGES + 1);
  localparam int IDX_W = $clog2(NSLOT + 1);
  localparam int TM_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TM_W-1:0] TM_LAST = TM_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_CTRL  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_SHOW  = 3'd4;

  logic [2:0]                state_q, state_d;
  logic [OP_W-1:0]           op_q, op_d;
  logic [PG_W-1:0]           page_q, page_d;
  logic [NUM_OPS*WORD_W-1:0] opBus_q, opBus_d;
  logic [CTRL_W-1:0]         ctrl_q, ctrl_d;
  logic [WORD_W-1:0]         result_q, result_d;
  logic [FLAG_W-1:0]         flags_q, flags_d;
  logic [TM_W-1:0]           timer_q, timer_d;
  logic                      timedOut_q, timedOut_d;
  logic [IDX_W-1:0]          stepIdx;

  // Linear page index; naturally equals NSLOT in CTRL because op has rolled past the last operand.
  assign stepIdx = IDX_W'(op_q) * IDX_W'(PAGES) + IDX_W'(page_q);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    page_d     = page_q;
    opBus_d    = opBus_q;
    ctrl_d     = ctrl_q;
    result_d   = result_q;
    flags_d    = flags_q;
    timer_d    = timer_q;
    timedOut_d = timedOut_q;
    case (state_q)
      S_LOAD: begin
        if (step) begin
          for (int k = 0; k < NSLOT; k++) begin
            if (stepIdx == IDX_W'(k)) opBus_d[k*SW_W +: SW_W] = sw;
          end
          if (page_q == PG_W'(PAGES - 1)) begin
            page_d = '0;
            op_d   = op_q + 1'b1;
            if (op_q == OP_W'(NUM_OPS - 1)) state_d = S_CTRL;
          end else begin
            page_d = page_q + 1'b1;
          end
        end
      end
      S_CTRL: begin
        if (step) begin
          ctrl_d     = sw[CTRL_W-1:0];
          timedOut_d = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A valid result on the final timeout cycle still counts as a normal completion.
        if (valid_in) begin
          result_d = result_in;
          flags_d  = flags_in;
          state_d  = S_SHOW;
        end else if ((TIMEOUT != 0) && (timer_q == TM_LAST)) begin
          result_d   = '0;
          flags_d    = '0;
          timedOut_d = 1'b1;
          state_d    = S_SHOW;
        end
      end
      S_SHOW: begin
        if (step) begin
          if (page_q == PG_W'(PAGES)) begin
            state_d = S_LOAD;
            op_d    = '0;
            page_d  = '0;
          end else begin
            page_d = page_q + 1'b1;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOAD;
      op_q       <= '0;
      page_q     <= '0;
      opBus_q    <= '0;
      ctrl_q     <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      timer_q    <= '0;
      timedOut_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      page_q     <= page_d;
      opBus_q    <= opBus_d;
      ctrl_q     <= ctrl_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      timer_q    <= timer_d;
      timedOut_q <= timedOut_d;
    end
  end

  always_comb begin
    led = '0;
    case (state_q)
      S_LOAD, S_CTRL: begin
`ifdef SEQ_ECHO_EN
        led = sw ^ {stepIdx[0], {(SW_W-1){1'b0}}};
`else
        led = SW_W'(stepIdx);
`endif
      end
      S_START, S_WAIT: led = '1;
      S_SHOW: begin
        led = SW_W'(flags_q);
        for (int k = 0; k < PAGES; k++) begin
          if (page_q == PG_W'(k)) led = result_q[k*SW_W +: SW_W];
        end
      end
      default: led = '0;
    endcase
  end

  assign op_bus    = opBus_q;
  assign ctrl      = ctrl_q;
  assign start     = (state_q == S_START);
  assign busy      = (state_q == S_START) || (state_q == S_WAIT);
  assign timed_out = timedOut_q;

endmodule
